// File: rtl/guess_round_ctrl.sv
// Bulls-and-Cows round sequencer: gathers four distinct BCD keys, pulses the
// scorer check, latches the score and tracks attempts until WIN or LOSE.
module guess_round_ctrl #(
  parameter int unsigned MAX_TRIES = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        digit_valid,
  input  logic [3:0]  digit,
  input  logic        clear,
  input  logic        new_game,
  input  logic [3:0]  strike,
  input  logic [3:0]  ball,
  output logic [15:0] guess,
  output logic        check_en,
  output logic [2:0]  entry_cnt,
  output logic [3:0]  try_cnt,
  output logic [3:0]  last_strike,
  output logic [3:0]  last_ball,
  output logic        dup_err,
  output logic        win,
  output logic        lose
);

  localparam logic [3:0] MAX_T = 4'(MAX_TRIES);

  typedef enum logic [2:0] {
    S_ENTRY,
    S_CHECK,
    S_RESULT,
    S_WIN,
    S_LOSE
  } state_t;

  state_t state, state_nxt;
  logic   is_dup;
  logic   key_ok;
  logic   accept;

  // Only the nibbles already entered take part in the duplicate compare.
  always_comb begin
    is_dup = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (i < 32'(entry_cnt) && guess[4*i +: 4] == digit)
        is_dup = 1'b1;
    end
  end

  assign key_ok = (digit <= 4'd9) && !is_dup;
  assign accept = (state == S_ENTRY) && digit_valid && !clear && !new_game && key_ok;

  // State register; win/lose are flopped alongside so they switch with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_ENTRY;
      win   <= 1'b0;
      lose  <= 1'b0;
    end else begin
      state <= state_nxt;
      win   <= (state_nxt == S_WIN);
      lose  <= (state_nxt == S_LOSE);
    end
  end

  always_comb begin
    state_nxt = state;
    if (new_game) begin
      state_nxt = S_ENTRY;
    end else begin
      unique case (state)
        S_ENTRY:  if (accept && entry_cnt == 3'd3) state_nxt = S_CHECK;
        S_CHECK:  state_nxt = S_RESULT;
        S_RESULT: begin
          if (last_strike == 4'd4)   state_nxt = S_WIN;
          else if (try_cnt == MAX_T) state_nxt = S_LOSE;
          else                       state_nxt = S_ENTRY;
        end
        S_WIN:    state_nxt = S_WIN;
        S_LOSE:   state_nxt = S_LOSE;
        default:  state_nxt = S_ENTRY;
      endcase
    end
  end

  always_comb begin
    check_en = (state == S_CHECK);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      guess       <= '1;
      entry_cnt   <= '0;
      try_cnt     <= '0;
      last_strike <= '0;
      last_ball   <= '0;
      dup_err     <= 1'b0;
    end else begin
      dup_err <= 1'b0;
      if (new_game) begin
        guess       <= '1;
        entry_cnt   <= '0;
        try_cnt     <= '0;
        last_strike <= '0;
        last_ball   <= '0;
      end else begin
        unique case (state)
          S_ENTRY: begin
            if (clear) begin
              guess     <= '1;
              entry_cnt <= '0;
            end else if (digit_valid) begin
              if (key_ok) begin
                guess     <= {guess[11:0], digit};
                entry_cnt <= entry_cnt + 3'd1;
              end else begin
                dup_err <= 1'b1;
              end
            end
          end
          S_CHECK: begin
            last_strike <= strike;
            last_ball   <= ball;
            if (try_cnt != MAX_T)
              try_cnt <= try_cnt + 4'd1;
          end
          S_RESULT: begin
            // Only a round that continues wipes the guess; WIN/LOSE keep it on display.
            if (last_strike != 4'd4 && try_cnt != MAX_T) begin
              guess     <= '1;
              entry_cnt <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_guess_round_ctrl.sv
// Scoreboard bench for guess_round_ctrl: stimulus queues expected check/dup/verdict events.
module tb_guess_round_ctrl;

  localparam int K_CHECK = 0;
  localparam int K_DUP   = 1;
  localparam int K_WIN   = 2;
  localparam int K_LOSE  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        digit_valid;
  logic [3:0]  digit;
  logic        clear;
  logic        new_game;
  logic [3:0]  strike;
  logic [3:0]  ball;
  logic [15:0] guess;
  logic        check_en;
  logic [2:0]  entry_cnt;
  logic [3:0]  try_cnt;
  logic [3:0]  last_strike;
  logic [3:0]  last_ball;
  logic        dup_err;
  logic        win;
  logic        lose;

  guess_round_ctrl #(.MAX_TRIES(3)) dut (
    .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit(digit),
    .clear(clear), .new_game(new_game), .strike(strike), .ball(ball),
    .guess(guess), .check_en(check_en), .entry_cnt(entry_cnt),
    .try_cnt(try_cnt), .last_strike(last_strike), .last_ball(last_ball),
    .dup_err(dup_err), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    int          cyc;
    logic [15:0] g;
    logic [2:0]  ec;
    logic [3:0]  tc;
    logic [3:0]  ls;
    logic [3:0]  lb;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic win_q = 1'b0;
  logic lose_q = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic take(input int kind);
    exp_t e;
    if (q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got kind %0d expected none (cyc=%0d)", kind, cyc);
    end else begin
      e = q.pop_front();
      chk("ev_kind", 16'(kind), 16'(e.kind));
      chk("ev_cycle", 16'(cyc), 16'(e.cyc));
      chk("ev_guess", guess, e.g);
      chk("ev_entry_cnt", 16'(entry_cnt), 16'(e.ec));
      chk("ev_try_cnt", 16'(try_cnt), 16'(e.tc));
      if (kind == K_WIN || kind == K_LOSE) begin
        chk("ev_last_strike", 16'(last_strike), 16'(e.ls));
        chk("ev_last_ball", 16'(last_ball), 16'(e.lb));
      end
    end
  endtask

  // Monitor: sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (check_en)       take(K_CHECK);
    if (dup_err)        take(K_DUP);
    if (win && !win_q)  take(K_WIN);
    if (lose && !lose_q) take(K_LOSE);
    win_q  = win;
    lose_q = lose;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    digit       = d;
    digit_valid = 1'b1;
    tick;
    digit_valid = 1'b0;
  endtask

  task automatic push(input int kind, input int dly, input logic [15:0] g, input logic [2:0] ec,
                      input logic [3:0] tc, input logic [3:0] ls, input logic [3:0] lb);
    exp_t e;
    e.kind = kind; e.cyc = cyc + dly; e.g = g; e.ec = ec; e.tc = tc; e.ls = ls; e.lb = lb;
    q.push_back(e);
  endtask

  task automatic pulse_new_game;
    new_game = 1'b1;
    tick;
    new_game = 1'b0;
  endtask

  initial begin
    rst = 1'b1; digit_valid = 1'b0; digit = '0; clear = 1'b0; new_game = 1'b0;
    strike = '0; ball = '0;
    #1 rst = 1'b0;
    #2;
    chk("rst_guess", guess, 16'hFFFF);
    chk("rst_entry_cnt", 16'(entry_cnt), 16'd0);
    chk("rst_try_cnt", 16'(try_cnt), 16'd0);
    chk("rst_flags", {11'd0, check_en, dup_err, win, lose, 1'b0}, 16'd0);
    chk("rst_last", {8'd0, last_strike, last_ball}, 16'd0);
    tick; tick;
    rst = 1'b1;
    tick;

    // 1: plain entry of 1,2,3,4 with idle cycles between keys
    strike = 4'd0; ball = 4'd2;
    key(4'd1); tick; key(4'd2); tick; key(4'd3); tick;
    key(4'd4); push(K_CHECK, 0, 16'h1234, 3'd4, 4'd0, 0, 0);
    tick; tick;
    chk("t1_guess_cleared", guess, 16'hFFFF);
    chk("t1_entry_cnt", 16'(entry_cnt), 16'd0);
    chk("t1_try_cnt", 16'(try_cnt), 16'd1);
    chk("t1_last_ball", 16'(last_ball), 16'd2);

    // 2: out-of-range key and duplicate are rejected
    strike = 4'd3; ball = 4'd0;
    key(4'hA); push(K_DUP, 0, 16'hFFFF, 3'd0, 4'd1, 0, 0);
    key(4'd5);
    key(4'd5); push(K_DUP, 0, 16'hFFF5, 3'd1, 4'd1, 0, 0);
    key(4'd6); key(4'd7);
    key(4'd8); push(K_CHECK, 0, 16'h5678, 3'd4, 4'd1, 0, 0);
    tick; tick;
    chk("t2_try_cnt", 16'(try_cnt), 16'd2);
    chk("t2_last_strike", 16'(last_strike), 16'd3);

    // 3: four strikes on the final allowed try wins rather than loses
    strike = 4'd4; ball = 4'd0;
    key(4'd3); key(4'd1); key(4'd4);
    key(4'd2);
    push(K_CHECK, 0, 16'h3142, 3'd4, 4'd2, 0, 0);
    push(K_WIN, 2, 16'h3142, 3'd4, 4'd3, 4'd4, 4'd0);
    tick; tick;
    key(4'd5);
    clear = 1'b1; tick; clear = 1'b0;
    tick;
    chk("t3_win_hold", {14'd0, win, lose}, 16'b10);
    chk("t3_guess_hold", guess, 16'h3142);
    chk("t3_entry_hold", 16'(entry_cnt), 16'd4);
    pulse_new_game;
    chk("t3_ng_flags", {14'd0, win, lose}, 16'd0);
    chk("t3_ng_try", 16'(try_cnt), 16'd0);
    chk("t3_ng_guess", guess, 16'hFFFF);
    chk("t3_ng_last", {8'd0, last_strike, last_ball}, 16'd0);

    // 4: three misses exhaust the tries
    strike = 4'd1; ball = 4'd2;
    key(4'd1); key(4'd2); key(4'd3);
    key(4'd4); push(K_CHECK, 0, 16'h1234, 3'd4, 4'd0, 0, 0);
    tick; tick;
    key(4'd5); key(4'd6); key(4'd7);
    key(4'd8); push(K_CHECK, 0, 16'h5678, 3'd4, 4'd1, 0, 0);
    tick; tick;
    key(4'd9); key(4'd0); key(4'd1);
    key(4'd2);
    push(K_CHECK, 0, 16'h9012, 3'd4, 4'd2, 0, 0);
    push(K_LOSE, 2, 16'h9012, 3'd4, 4'd3, 4'd1, 4'd2);
    tick; tick;
    key(4'd3); tick;
    chk("t4_lose_hold", {14'd0, win, lose}, 16'b01);
    chk("t4_try_sat", 16'(try_cnt), 16'd3);
    pulse_new_game;
    chk("t4_ng_flags", {14'd0, win, lose}, 16'd0);

    // 5: clear beats a coincident key; cleared digits are usable again
    strike = 4'd0; ball = 4'd0;
    key(4'd9); key(4'd8);
    clear = 1'b1; digit = 4'd7; digit_valid = 1'b1;
    tick;
    clear = 1'b0; digit_valid = 1'b0;
    chk("t5_clear_guess", guess, 16'hFFFF);
    chk("t5_clear_cnt", 16'(entry_cnt), 16'd0);
    key(4'd9); key(4'd8); key(4'd7);
    key(4'd6); push(K_CHECK, 0, 16'h9876, 3'd4, 4'd0, 0, 0);
    tick; tick;
    chk("t5_try_cnt", 16'(try_cnt), 16'd1);

    // 6: asynchronous reset mid-entry and during CHECK
    key(4'd1); key(4'd2);
    #2 rst = 1'b0;
    #1;
    chk("t6a_guess", guess, 16'hFFFF);
    chk("t6a_cnt", 16'(entry_cnt), 16'd0);
    chk("t6a_try", 16'(try_cnt), 16'd0);
    tick;
    rst = 1'b1;
    tick;
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    chk("t6b_check_live", 16'(check_en), 16'd1);
    rst = 1'b0;
    #1;
    chk("t6b_check_en", 16'(check_en), 16'd0);
    chk("t6b_guess", guess, 16'hFFFF);
    chk("t6b_cnt", 16'(entry_cnt), 16'd0);
    tick; tick;
    rst = 1'b1;
    tick; tick; tick;
    chk("t6b_idle_try", 16'(try_cnt), 16'd0);

    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      bad++;
      $display("FAIL missing_event: got none expected kind %0d at cyc %0d", e.kind, e.cyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
